// File: rtl/proc_core_param.sv
// Parametrised multi-cycle load/store core: FETCH -> EXE (-> MEM) with HALT/ERR sticky states.
// All outputs are registered; the instruction word is only sampled in EXE and MEM.
module proc_core_param #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned PC_W    = 8,
  parameter int unsigned REG_N   = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned RI_W    = $clog2(REG_N),
  localparam int unsigned INSTR_W = 4 + RI_W + WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic [WORD_W-1:0]  data_out,
  output logic               data_valid,
  output logic [1:0]         mem_rw,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [WORD_W-1:0]  mem_rdata,
  output logic [2:0]         state,
  output logic [1:0]         err_code
);

  typedef enum logic [2:0] {
    StFetch = 3'd0,
    StExe   = 3'd1,
    StMem   = 3'd2,
    StHalt  = 3'd3,
    StErr   = 3'd4
  } state_e;

  localparam logic [3:0] OpNop  = 4'd0;
  localparam logic [3:0] OpSet  = 4'd1;
  localparam logic [3:0] OpGet  = 4'd2;
  localparam logic [3:0] OpLd   = 4'd3;
  localparam logic [3:0] OpSt   = 4'd4;
  localparam logic [3:0] OpAdd  = 4'd5;
  localparam logic [3:0] OpSub  = 4'd6;
  localparam logic [3:0] OpBnz  = 4'd7;
  localparam logic [3:0] OpHalt = 4'd8;

  localparam logic [1:0] MemIdle  = 2'b00;
  localparam logic [1:0] MemRead  = 2'b01;
  localparam logic [1:0] MemWrite = 2'b10;

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            st;
  logic [WORD_W-1:0] regs [REG_N];
  logic [CntW-1:0]   wait_cnt;

  logic [3:0]        op;
  logic [RI_W-1:0]   rd;
  logic [RI_W-1:0]   rs;
  logic [WORD_W-1:0] imm;
  logic [WORD_W-1:0] rd_val;
  logic [WORD_W-1:0] rs_val;
  logic [PC_W-1:0]   pc_inc;
  logic              timeout_hit;

  assign op     = instruction[INSTR_W-1 -: 4];
  assign rd     = instruction[WORD_W +: RI_W];
  assign imm    = instruction[WORD_W-1:0];
  assign rs     = imm[RI_W-1:0];
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];
  assign pc_inc = pc + PC_W'(1);
  // Fires on the TIMEOUT-th consecutive ack-less MEM cycle; a zero TIMEOUT never fires.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CntLast);
  assign state  = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st         <= StFetch;
      pc         <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      mem_rw     <= MemIdle;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_code   <= 2'd0;
      wait_cnt   <= '0;
      for (int i = 0; i < REG_N; i++) regs[i] <= '0;
    end else begin
      data_valid <= 1'b0;
      unique case (st)
        StFetch: begin
          mem_rw <= MemIdle;
          st     <= StExe;
        end
        StExe: begin
          case (op)
            OpNop: begin
              pc <= pc_inc;
              st <= StFetch;
            end
            OpSet: begin
              regs[rd] <= imm;
              pc       <= pc_inc;
              st       <= StFetch;
            end
            OpGet: begin
              data_out   <= rd_val;
              data_valid <= 1'b1;
              pc         <= pc_inc;
              st         <= StFetch;
            end
            OpLd, OpSt: begin
              mem_rw   <= (op == OpLd) ? MemRead : MemWrite;
              mem_addr <= ADDR_W'(imm);
              if (op == OpSt) mem_wdata <= rd_val;
              wait_cnt <= '0;
              st       <= StMem;
            end
            OpAdd: begin
              regs[rd] <= rd_val + rs_val;
              pc       <= pc_inc;
              st       <= StFetch;
            end
            OpSub: begin
              regs[rd] <= rd_val - rs_val;
              pc       <= pc_inc;
              st       <= StFetch;
            end
            OpBnz: begin
              pc <= (rd_val != '0) ? PC_W'(imm) : pc_inc;
              st <= StFetch;
            end
            OpHalt: st <= StHalt;
            default: begin
              err_code <= 2'd1;
              st       <= StErr;
            end
          endcase
        end
        StMem: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (mem_ack) begin
            if (mem_rw == MemRead) regs[rd] <= mem_rdata;
            mem_rw <= MemIdle;
            pc     <= pc_inc;
            st     <= StFetch;
          end else begin
            wait_cnt <= wait_cnt + CntW'(1);
            if (timeout_hit) begin
              mem_rw   <= MemIdle;
              err_code <= 2'd2;
              st       <= StErr;
            end
          end
        end
        StHalt, StErr: mem_rw <= MemIdle;
        default: begin
          mem_rw <= MemIdle;
          st     <= StErr;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_core_param.sv
// Directed + randomized bench for proc_core_param against an instruction-level reference model.
module tb_proc_core_param;

  localparam int WORD_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int PC_W    = 8;
  localparam int REG_N   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] instruction = '0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  pc;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [1:0]  mem_rw;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [2:0]  state;
  logic [1:0]  err_code;

  proc_core_param #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .PC_W   (PC_W),
    .REG_N  (REG_N),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .pc         (pc),
    .data_out   (data_out),
    .data_valid (data_valid),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .state      (state),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Architectural model: registers, pc, last GET value, current state and error code.
  logic [7:0] m_regs [REG_N];
  logic [7:0] m_pc;
  logic [7:0] m_dout;
  logic [2:0] m_state;
  logic [1:0] m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_N; i++) m_regs[i] = 8'h00;
    m_pc = 8'h00; m_dout = 8'h00; m_state = 3'd0; m_err = 2'd0;
  endtask

  task automatic check_outputs_idle(input string tag);
    check({tag, "_state"}, state, m_state);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_err"}, err_code, m_err);
    check({tag, "_rw"}, mem_rw, 2'b00);
    check({tag, "_dv"}, data_valid, 1'b0);
    check({tag, "_dout"}, data_out, m_dout);
  endtask

  task automatic do_reset();
    reset = 1'b1; instruction = '0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check_outputs_idle("reset");
    check("reset_addr", mem_addr, 8'h00);
    check("reset_wdata", mem_wdata, 8'h00);
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH. ack_k = MEM cycle that carries the ack (0 = never).
  task automatic step(input logic [3:0] op, input logic [1:0] rd, input logic [7:0] imm,
                      input int ack_k, input logic [7:0] rdata);
    logic [7:0] rd_v, rs_v, idx;
    instruction = {op, rd, imm};
    check("fetch_state", state, 3'd0);
    @(negedge clk);
    check("exe_state", state, 3'd1);
    check("dv_one_cycle", data_valid, 1'b0);
    rd_v = m_regs[rd];
    idx  = imm;
    rs_v = m_regs[idx[1:0]];
    if (op == 4'd3 || op == 4'd4) begin
      @(negedge clk);
      for (int j = 1; j <= TIMEOUT; j++) begin
        check("mem_state", state, 3'd2);
        check("mem_rw", mem_rw, (op == 4'd3) ? 2'b01 : 2'b10);
        check("mem_addr", mem_addr, imm);
        if (op == 4'd4) check("mem_wdata", mem_wdata, rd_v);
        if (j == ack_k) begin mem_ack = 1'b1; mem_rdata = rdata; end
        @(negedge clk);
        mem_ack = 1'b0;
        if (j == ack_k) break;
      end
      if (ack_k >= 1 && ack_k <= TIMEOUT) begin
        if (op == 4'd3) m_regs[rd] = rdata;
        m_pc = m_pc + 8'd1;
      end else begin
        m_state = 3'd4; m_err = 2'd2;
      end
      check_outputs_idle("mem_done");
    end else begin
      case (op)
        4'd0: m_pc = m_pc + 8'd1;
        4'd1: begin m_regs[rd] = imm; m_pc = m_pc + 8'd1; end
        4'd2: begin m_dout = rd_v; m_pc = m_pc + 8'd1; end
        4'd5: begin m_regs[rd] = 8'((int'(rd_v) + int'(rs_v)) % 256); m_pc = m_pc + 8'd1; end
        4'd6: begin m_regs[rd] = 8'((int'(rd_v) - int'(rs_v) + 256) % 256); m_pc = m_pc + 8'd1; end
        4'd7: m_pc = (rd_v != 0) ? imm : m_pc + 8'd1;
        4'd8: m_state = 3'd3;
        default: begin m_state = 3'd4; m_err = 2'd1; end
      endcase
      @(negedge clk);
      check("exe_next_state", state, m_state);
      check("exe_pc", pc, m_pc);
      check("exe_err", err_code, m_err);
      check("exe_dout", data_out, m_dout);
      check("exe_dv", data_valid, (op == 4'd2) ? 1'b1 : 1'b0);
    end
  endtask

  task automatic get_all();
    for (int r = 0; r < REG_N; r++) step(4'd2, 2'(r), 8'h00, 0, 8'h00);
  endtask

  task automatic check_sticky(input string tag);
    for (int i = 0; i < 3; i++) begin
      mem_ack = 1'($urandom);
      instruction = 14'($urandom);
      @(negedge clk);
      check_outputs_idle(tag);
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    int taken;
    logic [7:0] loop_pc;
    logic [3:0] rop;
    model_reset();

    // Reset, SET and GET
    do_reset();
    step(4'd1, 2'd2, 8'h5A, 0, 8'h00);
    step(4'd2, 2'd2, 8'h00, 0, 8'h00);
    check("pc_after_two", pc, 8'd2);

    // ALU wrap
    step(4'd1, 2'd0, 8'hF0, 0, 8'h00);
    step(4'd1, 2'd1, 8'h20, 0, 8'h00);
    step(4'd5, 2'd0, 8'h01, 0, 8'h00);
    step(4'd2, 2'd0, 8'h00, 0, 8'h00);
    check("add_wrap", data_out, 8'h10);
    step(4'd6, 2'd1, 8'h01, 0, 8'h00);
    step(4'd2, 2'd1, 8'h00, 0, 8'h00);
    check("sub_self", data_out, 8'h00);

    // Store then load with delayed ack
    step(4'd4, 2'd0, 8'h33, 3, 8'h00);
    step(4'd3, 2'd3, 8'h33, 2, 8'h10);
    step(4'd2, 2'd3, 8'h00, 0, 8'h00);
    check("ld_value", data_out, 8'h10);

    // Branch loop: taken twice, falls through once
    step(4'd1, 2'd0, 8'd3, 0, 8'h00);
    step(4'd1, 2'd1, 8'd1, 0, 8'h00);
    loop_pc = m_pc;
    taken = 0;
    for (int i = 0; i < 3; i++) begin
      step(4'd6, 2'd0, 8'h01, 0, 8'h00);
      step(4'd7, 2'd0, loop_pc, 0, 8'h00);
      if (pc == loop_pc) taken++;
    end
    check("bnz_taken", taken, 2);
    step(4'd7, 2'd1, 8'hFF, 0, 8'h00);
    check("bnz_far", pc, 8'hFF);
    step(4'd0, 2'd0, 8'h00, 0, 8'h00);
    check("pc_wrap", pc, 8'h00);
    step(4'd8, 2'd0, 8'h00, 0, 8'h00);
    check_sticky("halt");

    // Timeout, then ack exactly on the last allowed cycle
    do_reset();
    step(4'd3, 2'd1, 8'h44, 0, 8'h00);
    check_sticky("timeout");
    do_reset();
    step(4'd3, 2'd1, 8'h44, TIMEOUT, 8'hA7);
    step(4'd2, 2'd1, 8'h00, 0, 8'h00);

    // Illegal op and recovery
    step(4'hC, 2'd2, 8'h00, 0, 8'h00);
    check_sticky("illegal");
    do_reset();

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 7));
      step(rop, 2'($urandom), 8'($urandom), $urandom_range(1, 5), 8'($urandom));
    end
    get_all();

    // Reset in the middle of an LD wait
    step(4'd1, 2'd3, 8'h77, 0, 8'h00);
    instruction = {4'd3, 2'd3, 8'h40};
    repeat (3) @(negedge clk);
    check("mid_mem_rw", mem_rw, 2'b01);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_outputs_idle("mid_mem_reset");
    get_all();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
